// File: rtl/bbc_cyc_pkg.sv
// Shared types and constants for the BBC host-bus cycle controller.
// Holds the cycle FSM encoding, the latched per-cycle attributes and register bit positions.
package bbc_cyc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_PHI1  = 3'd2,
        ST_PHI2  = 3'd3,
        ST_DONE  = 3'd4
    } cyc_state_e;

    // Bit positions inside the CPU write data for the two captured registers.
    localparam int SHADOW_BIT = 7;
    localparam int ROMSEL_LSB = 0;

    // Attributes of the current host cycle, frozen when the request is accepted.
    typedef struct packed {
        logic rnw;
        logic rom_reg;
        logic shadow_reg;
        logic fe4x;
    } cyc_attr_t;

    function automatic logic is_host_phase(input cyc_state_e s);
        return (s == ST_PHI1) || (s == ST_PHI2);
    endfunction

endpackage

// File: rtl/bbc_phi_sync.sv
// Brings the asynchronous host PHI0 into the hsclk domain and flags its edges.
// SYNC_STAGES must be at least 2.
module bbc_phi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic hsclk,
    input  logic rst,
    input  logic phi0_async,
    output logic phi0_s,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   phi0_d;

    always_ff @(posedge hsclk) begin
        if (rst) begin
            sync_q <= '0;
            phi0_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], phi0_async};
            phi0_d <= phi0_s;
        end
    end

    assign phi0_s = sync_q[SYNC_STAGES-1];
    assign fall   = phi0_d & ~phi0_s;
    assign rise   = ~phi0_d & phi0_s;

endmodule

// File: rtl/bbc_cycle_ctrl.sv
// Sequences CPU accesses onto the BBC host bus, stalling the CPU until the host cycle ends.
// Optional FE4X_STRETCH_EN: FE4x accesses run at 1MHz (phase-aligned, two PHI0 periods).
module bbc_cycle_ctrl
    import bbc_cyc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ROMSEL_W    = 4
) (
    input  logic                hsclk,
    input  logic                rst,
    input  logic                bbc_phi0,
    input  logic                cpu_req,
    input  logic                cpu_rnw,
    input  logic [7:0]          cpu_data,
    input  logic                dec_rom_reg,
    input  logic                dec_shadow_reg,
    input  logic                dec_fe4x,
    output logic                lat_en,
    output logic                cpu_rdy,
    output logic                bbc_cyc,
    output logic [ROMSEL_W-1:0] rom_sel_q,
    output logic                shadow_en_q,
    output logic                cyc_done
);

    cyc_state_e state_q, state_d;
    cyc_attr_t  attr_q;
    logic       phi0_s, phi0_fall, phi0_rise;
    logic       align_ok, stretch_pending, capture_ok;
    logic       unused_sigs;

    bbc_phi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_phi_sync (
        .hsclk     (hsclk),
        .rst       (rst),
        .phi0_async(bbc_phi0),
        .phi0_s    (phi0_s),
        .fall      (phi0_fall),
        .rise      (phi0_rise)
    );

`ifdef FE4X_STRETCH_EN
    logic phase_q;
    logic stretch_q;

    // phase_q tracks the 1MHz half of the host clock; FE4x cycles start on the
    // fall that moves it to 1 and then take an extra PHI1/PHI2 pass.
    always_ff @(posedge hsclk) begin
        if (rst) begin
            phase_q   <= 1'b0;
            stretch_q <= 1'b0;
        end else begin
            if (phi0_fall) begin
                phase_q <= ~phase_q;
            end
            if (state_q == ST_ALIGN && state_d == ST_PHI1) begin
                stretch_q <= attr_q.fe4x;
            end else if (state_q == ST_PHI2 && phi0_fall) begin
                stretch_q <= 1'b0;
            end
        end
    end

    assign align_ok        = ~attr_q.fe4x | ~phase_q;
    assign stretch_pending = stretch_q;
`else
    assign align_ok        = 1'b1;
    assign stretch_pending = 1'b0;
`endif

    always_ff @(posedge hsclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                // Withdrawing the request before the host phase starts aborts cleanly.
                if (!cpu_req) begin
                    state_d = ST_IDLE;
                end else if (phi0_fall && align_ok) begin
                    state_d = ST_PHI1;
                end
            end
            ST_PHI1: begin
                if (phi0_rise) begin
                    state_d = ST_PHI2;
                end
            end
            ST_PHI2: begin
                if (phi0_fall) begin
                    state_d = stretch_pending ? ST_PHI1 : ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        lat_en   = 1'b1;
        cpu_rdy  = 1'b1;
        bbc_cyc  = 1'b0;
        cyc_done = 1'b0;
        case (state_q)
            ST_ALIGN: begin
                cpu_rdy = 1'b0;
            end
            ST_PHI1, ST_PHI2: begin
                cpu_rdy = 1'b0;
                lat_en  = 1'b0;
                bbc_cyc = is_host_phase(state_q);
            end
            ST_DONE: begin
                cyc_done = 1'b1;
            end
            default: begin
                cpu_rdy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hsclk) begin
        if (rst) begin
            attr_q <= '0;
        end else if (state_q == ST_IDLE && cpu_req) begin
            attr_q <= '{rnw: cpu_rnw, rom_reg: dec_rom_reg,
                        shadow_reg: dec_shadow_reg, fe4x: dec_fe4x};
        end
    end

    // Both selects latched together is an illegal decode; neither register moves.
    assign capture_ok = (state_q == ST_DONE) && !attr_q.rnw
                        && (attr_q.rom_reg ^ attr_q.shadow_reg);

    always_ff @(posedge hsclk) begin
        if (rst) begin
            rom_sel_q   <= '0;
            shadow_en_q <= 1'b0;
        end else if (capture_ok) begin
            if (attr_q.rom_reg) begin
                rom_sel_q <= cpu_data[ROMSEL_LSB +: ROMSEL_W];
            end
            if (attr_q.shadow_reg) begin
                shadow_en_q <= cpu_data[SHADOW_BIT];
            end
        end
    end

    assign unused_sigs = ^{cpu_data, phi0_s, attr_q.fe4x};

endmodule

// File: doc/bbc_cycle_ctrl.md
Name: bbc_cycle_ctrl

Overview:
- Sequences every CPU access that targets the BBC host bus.
- Takes decode flags from the address decoder and generates that decoder's address-latch enable (lat_en).
- Synchronises to the asynchronous host PHI0, holds the fast CPU with cpu_rdy until the host cycle completes, and captures writes to the paged-ROM select and shadow-RAM select registers into local copies.

Parameters:
- SYNC_STAGES, 2, number of flops in the bbc_phi0 synchroniser (min 2).
- ROMSEL_W, 4, width of the captured paged-ROM select field, taken from cpu_data[ROMSEL_W-1:0].

Ports:
- hsclk  input  1  high-speed CPU-side clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- bbc_phi0  input  1  host 2MHz PHI0, asynchronous to hsclk.
- cpu_req  input  1  CPU requests a host-bus cycle; held until cpu_rdy returns high.
- cpu_rnw  input  1  1=read, 0=write; sampled with cpu_req.
- cpu_data  input  8  CPU write data; sampled at cycle end.
- dec_rom_reg  input  1  address is the paged-ROM select register.
- dec_shadow_reg  input  1  address is the shadow-RAM select register.
- dec_fe4x  input  1  address is in the FE4x (system VIA) page.
- lat_en  output  1  transparent-latch enable for the host address latch.
- cpu_rdy  output  1  0 = stall CPU.
- bbc_cyc  output  1  host-bus cycle in progress (buffer enable).
- rom_sel_q  output  ROMSEL_W  last value written to the paged-ROM select register.
- shadow_en_q  output  1  bit 7 of the last value written to the shadow-RAM select register.
- cyc_done  output  1  one-hsclk pulse when a host cycle completes.

Behaviour:
- Reset values:
  - lat_en=1, cpu_rdy=1, bbc_cyc=0, cyc_done=0.
  - rom_sel_q=0, shadow_en_q=0, FSM=IDLE.
  - Synchroniser flops cleared to 0.
- Synchroniser and edge detect:
  - phi0_s is the last synchroniser stage; phi0_d is phi0_s delayed one cycle.
  - fall = phi0_d & ~phi0_s; rise = ~phi0_d & phi0_s.
- FSM states: IDLE, ALIGN, PHI1, PHI2, DONE.
- IDLE: lat_en=1, cpu_rdy=1. On cpu_req go to ALIGN; cpu_rdy drops in the same cycle as the transition, i.e. registered low from the next edge.
- ALIGN: lat_en=1 (address tracks the CPU), cpu_rdy=0. On fall go to PHI1.
- PHI1: lat_en=0 (address frozen), bbc_cyc=1. On rise go to PHI2.
- PHI2: bbc_cyc=1. On fall go to DONE, unless a stretch is pending (see Optional Feature).
- DONE: one cycle.
  - bbc_cyc=0, cyc_done=1, cpu_rdy=1, lat_en=1.
  - Write capture, only when cpu_rnw=0:
    - dec_rom_reg → rom_sel_q <= cpu_data[ROMSEL_W-1:0].
    - dec_shadow_reg → shadow_en_q <= cpu_data[7].
  - Go to IDLE.
- Decode flags and cpu_rnw are latched on entry to ALIGN. Later changes are ignored for the rest of the cycle.
- If dec_rom_reg and dec_shadow_reg are both latched high (illegal), neither register updates.
- cpu_req low while in ALIGN: abort to IDLE with no host cycle. Not aborted from PHI1 onward.
- cpu_req still high in DONE: treated as a new request; IDLE→ALIGN on the next edge.
- fall and rise in the same cycle: cannot occur; no special handling.
- rst mid-cycle:
  - Immediate return to reset values.
  - Captured registers clear.
  - A partially completed write is not captured.
- Minimum latency, request to cpu_rdy: 1 + wait-for-fall + half PHI0 + half PHI0 + 1.

Optional Feature:
- Macro: FE4X_STRETCH_EN.
- Defined:
  - A 1-bit phase toggle flips on every fall (1MHz phase). Reset value 0.
  - dec_fe4x cycles leave ALIGN only on a fall where the toggle will become 1.
  - PHI2→DONE requires a second full PHI0 period: an extra PHI1/PHI2 pass with bbc_cyc held high.
- Undefined: FE4x cycles follow normal 2MHz timing; no toggle logic is built.

Decomposition:
- Package bbc_cyc_pkg:
  - FSM state enum (3-bit encoding).
  - Register bit positions: SHADOW_BIT=7, ROMSEL_LSB=0.
- One sub-module, bbc_phi_sync: the synchroniser and edge detector, parameterised by SYNC_STAGES, outputs phi0_s/fall/rise.

Test Plan:
- Idle after reset, bbc_phi0 free-running 2MHz vs hsclk 32MHz, no cpu_req → cpu_rdy=1, lat_en=1, bbc_cyc=0, rom_sel_q=0 indefinitely.
- Write 0x0C with dec_rom_reg=1, cpu_rnw=0 → cpu_rdy low until DONE; bbc_cyc high for one PHI0 period; rom_sel_q=4'hC; cyc_done one pulse.
- Write 0x80 with dec_shadow_reg → shadow_en_q=1. Then write 0x7F → shadow_en_q=0. rom_sel_q unchanged.
- Read with dec_rom_reg=1, data 0x05 → rom_sel_q unchanged. lat_en low exactly from PHI1 entry to DONE.
- Assert rst during PHI2 of a rom_reg write of 0x03 → all outputs at reset values next edge; rom_sel_q=0.
- With FE4X_STRETCH_EN, FE4x read → bbc_cyc high for two PHI0 periods, starting when the toggle becomes 1. Without the macro → one period.
